register_file_dumper: RTL and testbench

Sequential read-out controller for the 4-entry, 16-bit register file. On a `start` pulse it steps through every entry in index order, reading each one through the register file's read port. It presents each value on a valid/ready output stream with its index and a `last` marker. The block is the initiator on the register file's read port, the write port (when clear-on-read is compiled in), and the output stream. It sits between the register file and any consumer that needs a full snapshot, such as a debug or trace sink.

---
 rtl/register_file_dumper.sv | 93 +++++++++
 tb/tb_register_file_dumper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_dumper.sv
// Sequential read-out of a small register file onto a valid/ready stream with index and last marker.
// Optional clear-on-read write-back is compiled in with REGISTER_FILE_DUMPER_CLEAR_ON_READ_EN.
module register_file_dumper #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_read_index,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [ADDR_WIDTH-1:0] rf_write_index,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_write_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | rf_read_index = index, capture entry at the edge
  // SEND  | out_valid held until handshake, then next entry or done
  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = {ADDR_WIDTH{1'b1}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] index;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            index <= '0;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          out_data  <= rf_read_data;
          out_index <= index;
          out_last  <= (index == LAST_INDEX);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (index == LAST_INDEX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              index <= index + 1'b1;
              state <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_read_index = index;
  assign rf_write_data = '0;

`ifdef REGISTER_FILE_DUMPER_CLEAR_ON_READ_EN
  // Write-back is suppressed under reset so an abandoned beat never clears its entry.
  assign rf_write_enable = (state == SEND) && out_valid && out_ready && !reset;
  assign rf_write_index  = index;
`else
  assign rf_write_enable = 1'b0;
  assign rf_write_index  = '0;
`endif

endmodule

// File: tb/tb_register_file_dumper.sv
// Directed bench for register_file_dumper with a behavioural 4x16 register file.
module tb_register_file_dumper;
  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic        busy, done, rf_write_enable, out_valid, out_last;
  logic [1:0]  rf_read_index, rf_write_index, out_index;
  logic [15:0] rf_read_data, rf_write_data, out_data;

  logic [15:0] mem [4];
  logic [15:0] exp_data [4];
  int n_assert = 0;
  int n_fail = 0;
  int we_count = 0;

`ifdef REGISTER_FILE_DUMPER_CLEAR_ON_READ_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  always #5 clk = ~clk;

  register_file_dumper #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rf_read_index(rf_read_index), .rf_read_data(rf_read_data),
    .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last)
  );

  assign rf_read_data = mem[rf_read_index];

  always @(posedge clk) begin
    if (rf_write_enable) begin
      mem[rf_write_index] <= rf_write_data;
      we_count <= we_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    for (int i = 0; i < 4; i++) exp_data[i] = mem[i];
  endtask

  // One full dump; stall = cycles of out_ready low per beat, restart = pulse start during beat 1.
  task automatic do_dump(input int stall, input bit restart);
    int cyc;
    int t;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 1);
    check("valid_in_read", {31'd0, out_valid}, 0);
    check("read_index_first", {30'd0, rf_read_index}, 0);
    for (int b = 0; b < 4; b++) begin
      out_ready = (stall == 0);
      t = 0;
      while (!out_valid && t < 10) begin
        tick(); cyc++; t++;
      end
      if (t >= 10) begin
        check("beat_timeout", 0, 1);
        return;
      end
      check($sformatf("beat%0d_index", b), {30'd0, out_index}, b);
      check($sformatf("beat%0d_data", b), {16'd0, out_data}, {16'd0, exp_data[b]});
      check($sformatf("beat%0d_last", b), {31'd0, out_last}, (b == 3) ? 1 : 0);
      check($sformatf("beat%0d_busy", b), {31'd0, busy}, 1);
      for (int s = 0; s < stall; s++) begin
        check("stall_no_write", {31'd0, rf_write_enable}, 0);
        tick(); cyc++;
        check("stall_valid", {31'd0, out_valid}, 1);
        check("stall_index", {30'd0, out_index}, b);
        check("stall_data", {16'd0, out_data}, {16'd0, exp_data[b]});
      end
      out_ready = 1'b1;
      #1;
      check("hs_write_enable", {31'd0, rf_write_enable}, CLEAR ? 1 : 0);
      if (CLEAR) check("hs_write_index", {30'd0, rf_write_index}, b);
      check("hs_write_data", {16'd0, rf_write_data}, 0);
      if (restart && b == 1) start = 1'b1;
      tick(); cyc++;
      start = 1'b0;
      if (b < 3) check("done_early", {31'd0, done}, 0);
    end
    check("done_pulse", {31'd0, done}, 1);
    check("busy_at_done", {31'd0, busy}, 0);
    check("valid_at_done", {31'd0, out_valid}, 0);
    check("last_at_done", {31'd0, out_last}, 0);
    check("dump_cycles", cyc, 8 + 4 * stall + 1 * 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_single", {31'd0, done}, 0);
      check("no_queued_start", {31'd0, busy}, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    preload();
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", {16'd0, out_data}, 0);
    check("rst_index", {30'd0, out_index}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_rd_index", {30'd0, rf_read_index}, 0);
    check("rst_we", {31'd0, rf_write_enable}, 0);
    check("rst_wr_index", {30'd0, rf_write_index}, 0);
    reset = 1'b0;
    tick();

    // basic dump, then a second back-to-back dump without reloading
    do_dump(0, 1'b0);
    if (CLEAR) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cleared_entry%0d", i), {16'd0, mem[i]}, 0);
        exp_data[i] = 16'h0000;
      end
    end
    do_dump(0, 1'b0);

    // backpressure
    preload();
    do_dump(3, 1'b0);

    // start while busy, then a fresh start after done
    preload();
    do_dump(0, 1'b1);
    preload();
    do_dump(0, 1'b0);

    // reset during SEND of index 2
    preload();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_valid", {31'd0, out_valid}, 1);
    check("mid_index", {30'd0, out_index}, 2);
    reset = 1'b1;
    #1;
    check("mid_no_write", {31'd0, rf_write_enable}, 0);
    tick();
    reset = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_entry2_kept", {16'd0, mem[2]}, 16'h3333);
    tick();
    check("mid_rst_done_later", {31'd0, done}, 0);
    check("mid_rst_idle_valid", {31'd0, out_valid}, 0);
    preload();
    do_dump(0, 1'b0);

    // start together with reset: reset wins
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("start_rst_busy", {31'd0, busy}, 0);
    tick();
    check("start_rst_valid", {31'd0, out_valid}, 0);

    if (!CLEAR) check("never_written", we_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
